mult_share_arb: RTL and testbench
=================================

Name: mult_share_arb

Overview:
- Round-robin arbiter and scheduler that shares the single registered 8x8 multiplier in the modulation path between N requesters, e.g. the AM mix and the envelope scaler.
- Each cycle it grants at most one requester and steers that requester's operands to the multiplier.
- It tracks in-flight products with a tag pipeline and returns each product only to the requester that issued it.
- Sits between the oscillator/modulation logic and the multiplier instance.

Parameters:
- N, 2, number of requesters (2..4).
- W, 8, operand width; product width is 2*W.
- LAT, 1, multiplier latency in clk cycles from operands to product (1..4).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- en  in  1  grant enable; when low, no new grants are issued.
- req  in  N  level request per requester; operands must be held stable while req is high and not yet granted.
- op_a  in  N*W  operand A per requester; requester i uses bits [i*W +: W].
- op_b  in  N*W  operand B per requester, same packing as op_a.
- gnt  out  N  one-hot combinational grant; req[i]&gnt[i] means the operands are accepted this cycle.
- mul_a  out  W  operand A to the multiplier.
- mul_b  out  W  operand B to the multiplier.
- mul_p  in  2*W  product from the multiplier; valid LAT cycles after its operands.
- res  out  2*W  registered result.
- res_vld  out  N  one-hot, one-cycle result-valid pulse per requester.
- busy  out  1  high while any tag is in flight.

Behaviour:
- Reset, synchronous: res=0, res_vld=0, busy=0, tag pipeline cleared, round-robin pointer=0 (requester 0 highest priority). gnt is combinational and is 0 whenever rst=1.
- Arbitration, combinational: if en=1 and req!=0, gnt selects the first set req[i] scanning from ptr, ptr+1, ... mod N; otherwise gnt=0. Never more than one gnt bit high.
- Pointer update: on a grant to i, ptr <= (i+1) mod N. With no grant, ptr holds.
- Operand steering:
  - mul_a/mul_b = op_a/op_b slice of the granted requester.
  - With no grant they hold their last granted values (registered hold mux), so the multiplier input does not toggle. After reset they are 0.
- Tag pipeline: LAT stages of {valid, idx}.
  - Stage 0 loads {1, i} on a grant, else {0, x}.
  - Stages shift every cycle regardless of en, because the multiplier has no stall.
- Result: when the last tag stage is valid, on the next edge res <= mul_p and res_vld <= onehot(idx). Otherwise res_vld <= 0 and res holds.
- Total latency from accepted grant edge to res_vld high: LAT+1 cycles.
- Throughput: one grant per cycle. A lone requester holding req high is granted every cycle.
- Fairness: with all N requesting and en=1, grants rotate strictly. Worst-case wait is N-1 cycles.
- busy = OR of all tag valid bits.
- Boundary conditions:
  - req dropped before grant: legal, no effect.
  - en low mid-flight: in-flight tags still complete and return.
  - rst mid-flight: all in-flight results discarded; no res_vld after reset.
  - Grant and result in the same cycle: both occur independently.
  - The same requester may have up to LAT products in flight; results return in issue order.
- Products are unsigned; no truncation, res is full 2*W.

Test Plan:
- Reset: assert rst for 2 cycles with req=2'b11 and en=1 -> gnt=0, res_vld=0, busy=0. First grant after release goes to requester 0.
- Single requester: req=2'b01, op_a[7:0]=8'h0C, op_b[7:0]=8'h0A, LAT=1 -> gnt=01 every cycle, mul_a=0C, mul_b=0A. res=16'h0078 with res_vld=01, two cycles after the first grant edge.
- Contention: req=2'b11 held; r0 operands 3*5, r1 operands 8'hFF*8'hFF -> gnt sequence 01,10,01,10. Results alternate 16'h000F on res_vld=01 and 16'hFE01 on res_vld=10.
- Enable gating: req=11, en=0 for 3 cycles -> gnt=0 and mul_a/mul_b hold. A product in flight before en fell still returns with the correct res_vld bit.
- Reset mid-flight: grant r1, assert rst on the next cycle -> no res_vld ever pulses for that grant, and ptr=0 after reset.
- LAT=3, N=3, all requesting -> gnt rotates 001,010,100. Each res_vld arrives 4 cycles after its grant, and busy stays high throughout.

Source files
------------

// File: rtl/mult_share_arb.sv
// rtl/mult_share_arb.sv - round-robin sharing of one registered multiplier among N requesters
module mult_share_arb #(
  parameter int N   = 2,
  parameter int W   = 8,
  parameter int LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N-1:0]     req,
  input  logic [N*W-1:0]   op_a,
  input  logic [N*W-1:0]   op_b,
  output logic [N-1:0]     gnt,
  output logic [W-1:0]     mul_a,
  output logic [W-1:0]     mul_b,
  input  logic [2*W-1:0]   mul_p,
  output logic [2*W-1:0]   res,
  output logic [N-1:0]     res_vld,
  output logic             busy
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [IW-1:0]  ptr;
  logic [IW-1:0]  gntIdx;
  logic           gntAny;
  logic [IW-1:0]  nextPtr;
  logic [W-1:0]   selA;
  logic [W-1:0]   selB;
  logic [W-1:0]   holdA;
  logic [W-1:0]   holdB;
  logic [LAT-1:0] tagVld;
  logic [IW-1:0]  tagIdx [LAT];

  // Scan from the pointer so the most recently served requester drops to lowest priority.
  always_comb begin
    gnt    = '0;
    gntIdx = '0;
    gntAny = 1'b0;
    if (!rst && en) begin
      for (int j = 0; j < N; j++) begin
        if (!gntAny && req[(int'(ptr) + j) % N]) begin
          gntAny = 1'b1;
          gntIdx = IW'((int'(ptr) + j) % N);
        end
      end
    end
    if (gntAny) begin
      gnt[gntIdx] = 1'b1;
    end
  end

  assign nextPtr = (int'(gntIdx) == N - 1) ? '0 : gntIdx + 1'b1;
  assign selA    = op_a[gntIdx*W +: W];
  assign selB    = op_b[gntIdx*W +: W];

  // Idle cycles replay the last granted operands so the multiplier inputs stay quiet.
  assign mul_a = gntAny ? selA : holdA;
  assign mul_b = gntAny ? selB : holdB;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr   <= '0;
      holdA <= '0;
      holdB <= '0;
    end else if (gntAny) begin
      ptr   <= nextPtr;
      holdA <= selA;
      holdB <= selB;
    end
  end

  // The tag shift tracks the multiplier pipeline, which never stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < LAT; s++) begin
        tagVld[s] <= 1'b0;
        tagIdx[s] <= '0;
      end
    end else begin
      tagVld[0] <= gntAny;
      tagIdx[0] <= gntIdx;
      for (int s = 1; s < LAT; s++) begin
        tagVld[s] <= tagVld[s-1];
        tagIdx[s] <= tagIdx[s-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res     <= '0;
      res_vld <= '0;
    end else if (tagVld[LAT-1]) begin
      res     <= mul_p;
      res_vld <= N'(1) << tagIdx[LAT-1];
    end else begin
      res_vld <= '0;
    end
  end

  assign busy = |tagVld;

endmodule

// File: tb/tb_mult_share_arb.sv
// tb/tb_mult_share_arb.sv - randomized and directed bench for mult_share_arb
module tb_mult_share_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, en;
  logic [1:0]  req2;
  logic [15:0] opA2, opB2;
  logic [2:0]  req3;
  logic [23:0] opA3, opB3;

  logic [1:0]  gnt2, vld2;
  logic [7:0]  mulA2, mulB2;
  logic [15:0] mulP2, res2;
  logic        busy2;
  logic [2:0]  gnt3, vld3;
  logic [7:0]  mulA3, mulB3;
  logic [15:0] mulP3, res3;
  logic        busy3;

  logic [15:0] p3a, p3b;

  mult_share_arb #(.N(2), .W(8), .LAT(1)) dut2 (
    .clk(clk), .rst(rst), .en(en), .req(req2), .op_a(opA2), .op_b(opB2),
    .gnt(gnt2), .mul_a(mulA2), .mul_b(mulB2), .mul_p(mulP2),
    .res(res2), .res_vld(vld2), .busy(busy2)
  );

  mult_share_arb #(.N(3), .W(8), .LAT(3)) dut3 (
    .clk(clk), .rst(rst), .en(en), .req(req3), .op_a(opA3), .op_b(opB3),
    .gnt(gnt3), .mul_a(mulA3), .mul_b(mulB3), .mul_p(mulP3),
    .res(res3), .res_vld(vld3), .busy(busy3)
  );

  // Registered multipliers with latency 1 and 3.
  always @(posedge clk) begin
    mulP2 <= mulA2 * mulB2;
    p3a   <= mulA3 * mulB3;
    p3b   <= p3a;
    mulP3 <= p3b;
  end

  typedef struct {
    int          inst;
    int          due;
    int          idx;
    logic [15:0] prod;
  } pend_t;

  pend_t       pq[$];
  int          ptr[2];
  logic [7:0]  hA[2], hB[2];
  logic [15:0] eRes[2];
  int          cyc;
  int          compared;
  int          mismatched;

  function automatic logic [3:0] getReq(int inst);
    return (inst != 0) ? {1'b0, req3} : {2'b00, req2};
  endfunction

  function automatic logic [7:0] getOp(int inst, bit isB, int idx);
    if (inst != 0) return isB ? opB3[idx*8 +: 8] : opA3[idx*8 +: 8];
    return isB ? opB2[idx*8 +: 8] : opA2[idx*8 +: 8];
  endfunction

  task automatic chk(string tag, int inst, logic [31:0] obs, logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s[inst%0d] cyc=%0d observed=%h expected=%h", tag, inst, cyc, obs, exp);
    end
  endtask

  // One clock cycle: check outputs against the model, then advance the model past the edge.
  task automatic tick(bit doCheck);
    #1;
    for (int inst = 0; inst < 2; inst++) begin
      int          n;
      int          lat;
      int          gi;
      logic [3:0]  r;
      logic [3:0]  eg;
      logic [3:0]  ev;
      bit          eBusy;
      logic [7:0]  ea, eb;
      pend_t       keep[$];
      n     = (inst != 0) ? 3 : 2;
      lat   = (inst != 0) ? 3 : 1;
      r     = getReq(inst);
      gi    = -1;
      eg    = '0;
      ev    = '0;
      eBusy = 1'b0;
      if (!rst && en) begin
        for (int j = 0; j < n; j++) begin
          if (gi < 0 && r[(ptr[inst] + j) % n]) gi = (ptr[inst] + j) % n;
        end
      end
      if (gi >= 0) begin
        eg = 4'(1) << gi;
        ea = getOp(inst, 1'b0, gi);
        eb = getOp(inst, 1'b1, gi);
      end else begin
        ea = hA[inst];
        eb = hB[inst];
      end
      foreach (pq[q]) begin
        if (pq[q].inst == inst) begin
          if (pq[q].due == cyc) begin
            ev         = 4'(1) << pq[q].idx;
            eRes[inst] = pq[q].prod;
          end
          if (pq[q].due > cyc) eBusy = 1'b1;
        end
      end
      if (doCheck) begin
        if (inst != 0) begin
          chk("gnt", inst, {29'd0, gnt3}, {28'd0, eg});
          chk("mul_a", inst, {24'd0, mulA3}, {24'd0, ea});
          chk("mul_b", inst, {24'd0, mulB3}, {24'd0, eb});
          chk("res", inst, {16'd0, res3}, {16'd0, eRes[inst]});
          chk("res_vld", inst, {29'd0, vld3}, {28'd0, ev});
          chk("busy", inst, {31'd0, busy3}, {31'd0, eBusy});
        end else begin
          chk("gnt", inst, {30'd0, gnt2}, {28'd0, eg});
          chk("mul_a", inst, {24'd0, mulA2}, {24'd0, ea});
          chk("mul_b", inst, {24'd0, mulB2}, {24'd0, eb});
          chk("res", inst, {16'd0, res2}, {16'd0, eRes[inst]});
          chk("res_vld", inst, {30'd0, vld2}, {28'd0, ev});
          chk("busy", inst, {31'd0, busy2}, {31'd0, eBusy});
        end
      end
      foreach (pq[q]) begin
        if (pq[q].inst != inst || (!rst && pq[q].due > cyc)) keep.push_back(pq[q]);
      end
      pq = keep;
      if (rst) begin
        ptr[inst]  = 0;
        hA[inst]   = '0;
        hB[inst]   = '0;
        eRes[inst] = '0;
      end else if (gi >= 0) begin
        ptr[inst] = (gi + 1) % n;
        hA[inst]  = ea;
        hB[inst]  = eb;
        pq.push_back('{inst: inst, due: cyc + lat + 1, idx: gi, prod: 16'(ea) * 16'(eb)});
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    cyc        = 0;
    rst  = 1'b1;
    en   = 1'b1;
    req2 = 2'b11;
    req3 = 3'b111;
    opA2 = '0; opB2 = '0; opA3 = '0; opB3 = '0;
    @(negedge clk);
    tick(1'b0);

    // Reset held with everyone requesting.
    repeat (2) tick(1'b1);

    // Lone requester 0: 0x0C * 0x0A; the N=3 instance sees all three requesting.
    rst  = 1'b0;
    req2 = 2'b01;
    opA2 = 16'h000C; opB2 = 16'h000A;
    opA3 = 24'h030201; opB3 = 24'h070605;
    repeat (5) tick(1'b1);

    // Contention: 3*5 against 0xFF*0xFF.
    req2 = 2'b11;
    opA2 = 16'hFF03; opB2 = 16'hFF05;
    opA3 = 24'hFF1122; opB3 = 24'hFE3344;
    repeat (6) tick(1'b1);

    // Enable low for three cycles with products still in flight.
    en = 1'b0;
    repeat (3) tick(1'b1);
    en = 1'b1;
    repeat (2) tick(1'b1);

    // Reset right after a grant to requester 1.
    req2 = 2'b10;
    req3 = 3'b010;
    tick(1'b1);
    rst  = 1'b1;
    req2 = 2'b00;
    req3 = 3'b000;
    tick(1'b1);
    rst = 1'b0;
    repeat (5) tick(1'b1);
    req2 = 2'b11;
    req3 = 3'b111;
    tick(1'b1);

    // Drain.
    req2 = 2'b00;
    req3 = 3'b000;
    repeat (5) tick(1'b1);

    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      req2 = 2'($urandom);
      req3 = 3'($urandom);
      opA2 = 16'($urandom); opB2 = 16'($urandom);
      opA3 = 24'($urandom); opB3 = 24'($urandom);
      en   = ($urandom_range(0, 7) != 0);
      rst  = ($urandom_range(0, 39) == 0);
      tick(1'b1);
    end
    rst  = 1'b0;
    req2 = 2'b00;
    req3 = 3'b000;
    repeat (6) tick(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
